anim_sequencer: RTL and testbench



---
 rtl/anim_sequencer.sv | 146 ++++++++++++++
 tb/tb_anim_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// anim_sequencer: per-frame animation controller for the black-hole renderer.
// Detects the vsync rising edge (end of the sync pulse, inside vertical
// blanking), keeps a frame counter and ring scroll phase, and drives the
// wait/fall/land motion of the "UW" text. All outputs move only on frame_tick.
// Optional build macro: ANIM_BOUNCE_EN adds a bounce (RISE state) on hard landings.
//
// state | meaning
// ------+---------------------------------------------------------------
// WAIT  | text parked at TEXT_Y_TOP, counting WAIT_FRAMES ticks
// FALL  | text accelerates downward, velocity capped at VMAX
// LAND  | text resting on TEXT_Y_FLOOR and blinking, counting HOLD_FRAMES
// RISE  | bounce upward with decaying velocity (ANIM_BOUNCE_EN only)
module anim_sequencer #(
  parameter int unsigned TEXT_Y_TOP   = 20,
  parameter int unsigned TEXT_Y_FLOOR = 276,
  parameter int unsigned WAIT_FRAMES  = 256,
  parameter int unsigned HOLD_FRAMES  = 64,
  parameter int unsigned VMAX         = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        enable,
  output logic        frame_tick,
  output logic [15:0] frame_cnt,
  output logic [7:0]  ring_phase,
  output logic [9:0]  text_y,
  output logic        text_visible,
  output logic [1:0]  anim_state
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FALL = 2'd1,
    ST_LAND = 2'd2,
    ST_RISE = 2'd3
  } state_t;

  localparam logic [9:0]  Y_TOP     = 10'(TEXT_Y_TOP);
  localparam logic [9:0]  Y_FLOOR   = 10'(TEXT_Y_FLOOR);
  localparam logic [10:0] Y_FLOOR_W = 11'(TEXT_Y_FLOOR);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_FRAMES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [5:0]  VEL_MAX   = 6'(VMAX);

  state_t      state;
  logic        vsync_q;
  logic [5:0]  vel;
  logic [15:0] ctr;
  logic        det;
  logic [15:0] cnt_nxt;
  logic [10:0] sum;

  assign det        = vsync & ~vsync_q;
  assign cnt_nxt    = frame_cnt + 16'd1;
  // 11-bit sum so a fast fall past the floor cannot wrap
  assign sum        = {1'b0, text_y} + {5'b0, vel};
  assign anim_state = state;

  // Frame edge detect, counters and motion FSM, all advanced on the frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      frame_tick   <= 1'b0;
      frame_cnt    <= '0;
      ring_phase   <= '0;
      text_y       <= Y_TOP;
      text_visible <= 1'b1;
      state        <= ST_WAIT;
      vel          <= '0;
      ctr          <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= det;
      if (det) begin
        frame_cnt    <= cnt_nxt;
        // blink tracks the new frame count even while frozen in LAND
        text_visible <= (state == ST_LAND) ? ~cnt_nxt[3] : 1'b1;
        if (enable) begin
          ring_phase <= ring_phase + 8'd1;
          case (state)
            ST_WAIT: begin
              if (ctr == WAIT_LAST) begin
                ctr   <= '0;
                vel   <= 6'd1;
                state <= ST_FALL;
              end else begin
                ctr <= ctr + 16'd1;
              end
            end
            ST_FALL: begin
              if (sum >= Y_FLOOR_W) begin
                text_y <= Y_FLOOR;
`ifdef ANIM_BOUNCE_EN
                if (vel >= 6'd4) begin
                  vel   <= vel >> 1;
                  state <= ST_RISE;
                end else begin
                  state        <= ST_LAND;
                  text_visible <= ~cnt_nxt[3];
                end
`else
                state        <= ST_LAND;
                text_visible <= ~cnt_nxt[3];
`endif
              end else begin
                text_y <= sum[9:0];
                vel    <= (vel >= VEL_MAX) ? VEL_MAX : vel + 6'd1;
              end
            end
            ST_LAND: begin
              if (ctr == HOLD_LAST) begin
                ctr          <= '0;
                text_y       <= Y_TOP;
                vel          <= '0;
                state        <= ST_WAIT;
                text_visible <= 1'b1;
              end else begin
                ctr <= ctr + 16'd1;
              end
            end
            ST_RISE: begin
`ifdef ANIM_BOUNCE_EN
              text_y <= text_y - {4'b0, vel};
              if (vel == 6'd1) begin
                vel   <= 6'd1;
                state <= ST_FALL;
              end else begin
                vel <= vel - 6'd1;
              end
`else
              // unreachable in this build; recover to a clean WAIT
              text_y <= Y_TOP;
              vel    <= '0;
              ctr    <= '0;
              state  <= ST_WAIT;
`endif
            end
            default: state <= ST_WAIT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: randomized frame stimulus against a behavioural model.
module tb_anim_sequencer;

  localparam int Y_TOP   = 20;
  localparam int Y_FLOOR = 276;
  localparam int WAITF   = 256;
  localparam int HOLDF   = 64;
  localparam int VMAXV   = 15;

  logic        clk = 1'b0;
  logic        reset, vsync, enable;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic [7:0]  ring_phase;
  logic [9:0]  text_y;
  logic        text_visible;
  logic [1:0]  anim_state;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 wait, 1 fall, 2 land, 3 rise
  int m_cnt, m_phase, m_state, m_y, m_vel, m_ctr;
  int fall_k;
  bit from_wait;
  bit seen_land;

  anim_sequencer dut (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt), .ring_phase(ring_phase),
    .text_y(text_y), .text_visible(text_visible), .anim_state(anim_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_state = 0; m_y = Y_TOP; m_vel = 0; m_ctr = 0;
    fall_k = 0; from_wait = 0;
  endtask

  task automatic model_tick(input bit en);
    int s;
    m_cnt = (m_cnt + 1) % 65536;
    if (en) begin
      m_phase = (m_phase + 1) % 256;
      case (m_state)
        0: if (m_ctr == WAITF - 1) begin
             m_ctr = 0; m_vel = 1; m_state = 1; fall_k = 0; from_wait = 1;
           end else m_ctr++;
        1: begin
          s = m_y + m_vel;
          if (s >= Y_FLOOR) begin
            m_y = Y_FLOOR;
            from_wait = 0;
`ifdef ANIM_BOUNCE_EN
            if (m_vel >= 4) begin m_vel = m_vel / 2; m_state = 3; end
            else begin m_state = 2; seen_land = 1; end
`else
            m_state = 2; seen_land = 1;
`endif
          end else begin
            m_y = s;
            m_vel = (m_vel + 1 > VMAXV) ? VMAXV : m_vel + 1;
            fall_k++;
          end
        end
        2: if (m_ctr == HOLDF - 1) begin
             m_ctr = 0; m_y = Y_TOP; m_vel = 0; m_state = 0;
           end else m_ctr++;
        default: begin
          m_y = m_y - m_vel;
          m_vel = m_vel - 1;
          if (m_vel == 0) begin m_vel = 1; m_state = 1; end
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_frame_cnt"}, frame_cnt, m_cnt);
    chk({ph, "_ring_phase"}, ring_phase, m_phase);
    chk({ph, "_anim_state"}, anim_state, m_state);
    chk({ph, "_text_y"}, text_y, m_y);
    chk({ph, "_text_visible"}, text_visible,
        (m_state == 2) ? ((m_cnt >> 3) & 1) ^ 1 : 1);
  endtask

  task automatic do_frame(input bit en);
    int low_len;
    int idle;
    low_len = $urandom_range(1, 3);
    idle    = $urandom_range(0, 2);
    enable = en;
    vsync  = 1'b0;
    repeat (low_len) begin
      step();
      chk("no_tick_low", frame_tick, 0);
    end
    vsync = 1'b1;
    step();
    model_tick(en);
    chk("tick_pulse", frame_tick, 1);
    check_outputs("tick");
    // closed form of the first fall leg, valid until velocity saturates
    if (en && m_state == 1 && from_wait && fall_k >= 1 && fall_k <= 15)
      chk("fall_closed_form", text_y, Y_TOP + fall_k * (fall_k + 1) / 2);
    step();
    chk("tick_one_cycle", frame_tick, 0);
    repeat (idle) begin
      step();
      chk("no_tick_high", frame_tick, 0);
    end
    chk("y_in_range", (text_y >= Y_TOP && text_y <= Y_FLOOR), 1);
  endtask

  task automatic rand_frame();
    do_frame($urandom_range(0, 7) != 0);
  endtask

  initial begin
    int guard;
    logic [15:0] s_cnt;
    logic [7:0]  s_phase;
    logic [9:0]  s_y;
    logic [1:0]  s_state;

    reset = 1'b1; vsync = 1'b1; enable = 1'b1;
    step(); step();
    reset = 1'b0;
    model_reset();
    seen_land = 0;
    chk("rst_frame_tick", frame_tick, 0);
    check_outputs("rst");
    repeat (3) begin
      step();
      chk("no_tick_after_rst", frame_tick, 0);
    end

    // first frame: exactly one tick, count and phase both 1
    do_frame(1'b1);
    chk("first_frame_cnt", frame_cnt, 1);
    chk("first_ring_phase", ring_phase, 1);

    // run through WAIT into FALL
    guard = 0;
    while (!(m_state == 1 && fall_k == 3) && guard < 600) begin
      rand_frame();
      guard++;
    end
    chk("reach_fall_bound", guard < 600, 1);

    // freeze mid-FALL for 10 ticks
    s_cnt = frame_cnt; s_phase = ring_phase; s_y = text_y; s_state = anim_state;
    repeat (10) do_frame(1'b0);
    chk("pause_frame_cnt", frame_cnt, 16'(s_cnt + 16'd10));
    chk("pause_ring_phase", ring_phase, s_phase);
    chk("pause_text_y", text_y, s_y);
    chk("pause_state", anim_state, s_state);

    // finish the fall, land, blink, and return to WAIT
    guard = 0;
    while (!(seen_land && m_state == 0) && guard < 800) begin
      rand_frame();
      guard++;
    end
    chk("return_wait_bound", guard < 800, 1);
    chk("return_wait_y", text_y, Y_TOP);
    chk("return_wait_vis", text_visible, 1);

    // back into FALL, then reset mid-fall
    guard = 0;
    while (!(m_state == 1 && fall_k >= 3) && guard < 600) begin
      rand_frame();
      guard++;
    end
    chk("reach_fall2_bound", guard < 600, 1);
    enable = 1'b1;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("midrst_frame_tick", frame_tick, 0);
    check_outputs("midrst");
    repeat (4) begin
      step();
      chk("midrst_no_tick", frame_tick, 0);
    end
    repeat (5) rand_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
